// File: rtl/serial_hamming_encoder.sv
// Serial (2^M-1, K) Hamming encoder with valid/ready bit streams on both sides.
// Define HAMMING_OVERALL_PARITY_EN to prepend an even overall parity bit (position 0).
module serial_hamming_encoder #(
    parameter int M = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic in,
    output logic out_valid,
    input  logic out_ready,
    output logic out,
    output logic out_sop,
    output logic out_eop
);

    localparam int NPOS = 1 << M;
    localparam int K    = NPOS - 1 - M;
`ifdef HAMMING_OVERALL_PARITY_EN
    localparam int N    = NPOS;
`else
    localparam int N    = NPOS - 1;
`endif
    localparam int CW   = $clog2(K + 1);
    localparam int IW   = $clog2(N);

    // Data positions (non-powers of two) that contribute to parity bit j.
    function automatic logic [NPOS-1:0] parity_mask(input int j);
        logic [NPOS-1:0] m;
        m = '0;
        for (int p = 1; p < NPOS; p++) begin
            if (((p & (p - 1)) != 0) && (((p >> j) & 1) != 0)) begin
                m[p] = 1'b1;
            end
        end
        return m;
    endfunction

    // Input collector state
    logic [K-1:0]  data_reg;
    logic [K-1:0]  data_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full_reg;
    logic          full_next;

    // Output shifter state
    logic [N-1:0]  shift_reg;
    logic [N-1:0]  shift_next;
    logic [IW-1:0] idx_reg;
    logic [IW-1:0] idx_next;
    logic          busy_reg;
    logic          busy_next;

    logic              in_accept;
    logic              last_accept;
    logic              load;
    logic [NPOS-1:1]   data_pos;
    logic [NPOS-1:1]   codeword;
    logic [M-1:0]      parity_bits;
    logic [N-1:0]      load_word;

    assign in_ready    = !full_reg;
    assign in_accept   = in_valid && !full_reg;
    assign last_accept = busy_reg && out_ready && (idx_reg == IW'(N - 1));
    assign load        = full_reg && (!busy_reg || last_accept);

    // Place d_0..d_{K-1} at ascending non-power-of-two positions.
    genvar gi;
    generate
        for (gi = 1; gi < NPOS; gi++) begin : g_pos
            if ((gi & (gi - 1)) != 0) begin : g_data
                assign data_pos[gi] = data_reg[gi - $clog2(gi + 1) - 1];
                assign codeword[gi] = data_reg[gi - $clog2(gi + 1) - 1];
            end else begin : g_parity
                assign data_pos[gi] = 1'b0;
                assign codeword[gi] = parity_bits[$clog2(gi)];
            end
        end

        for (gi = 0; gi < M; gi++) begin : g_par
            assign parity_bits[gi] = ^({data_pos, 1'b0} & parity_mask(gi));
        end
    endgenerate

    // Bit 0 of the shifter is always the next bit on the wire.
`ifdef HAMMING_OVERALL_PARITY_EN
    logic overall_parity;
    assign overall_parity = ^codeword;
    assign load_word      = {codeword, overall_parity};
`else
    assign load_word      = codeword;
`endif

    always_comb begin
        data_next  = data_reg;
        count_next = count_reg;
        full_next  = full_reg;
        if (in_accept) begin
            data_next = {in, data_reg[K-1:1]};
            if (count_reg == CW'(K - 1)) begin
                count_next = '0;
                full_next  = 1'b1;
            end else begin
                count_next = count_reg + CW'(1);
            end
        end else if (load) begin
            full_next = 1'b0;
        end
    end

    always_comb begin
        shift_next = shift_reg;
        idx_next   = idx_reg;
        busy_next  = busy_reg;
        if (load) begin
            shift_next = load_word;
            idx_next   = '0;
            busy_next  = 1'b1;
        end else if (busy_reg && out_ready) begin
            if (last_accept) begin
                busy_next = 1'b0;
            end else begin
                shift_next = {1'b0, shift_reg[N-1:1]};
                idx_next   = idx_reg + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg  <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else begin
            data_reg  <= data_next;
            count_reg <= count_next;
            full_reg  <= full_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            busy_reg  <= busy_next;
        end
    end

    // Outputs are gated by busy so they sit at zero between words.
    assign out_valid = busy_reg;
    assign out       = busy_reg && shift_reg[0];
    assign out_sop   = busy_reg && (idx_reg == '0);
    assign out_eop   = busy_reg && (idx_reg == IW'(N - 1));

endmodule

// File: tb/tb_serial_hamming_encoder.sv
// Directed bench for serial_hamming_encoder: M=3 and M=4 instances, expectations hand-computed.
module tb_serial_hamming_encoder;

`ifdef HAMMING_OVERALL_PARITY_EN
    localparam int N3 = 8;
    localparam int N4 = 16;
    localparam logic [63:0] A_VEC = 64'hCC;  // d=1,0,1,1 -> 0,0,1,1,0,0,1,1
    localparam logic [63:0] B_VEC = 64'h66;  // d=0,1,1,0 -> 0,1,1,0,0,1,1,0
`else
    localparam int N3 = 7;
    localparam int N4 = 15;
    localparam logic [63:0] A_VEC = 64'h66;  // d=1,0,1,1 -> 0,1,1,0,0,1,1
    localparam logic [63:0] B_VEC = 64'h33;  // d=0,1,1,0 -> 1,1,0,0,1,1,0
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid, in_bit, in_ready, out_valid, out_ready, out_bit, out_sop, out_eop;
    logic in_valid4, in_bit4, in_ready4, out_valid4, out_ready4, out_bit4, out_sop4, out_eop4;

    serial_hamming_encoder #(.M(3)) u_dut3 (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in(in_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out(out_bit),
        .out_sop(out_sop), .out_eop(out_eop)
    );

    serial_hamming_encoder #(.M(4)) u_dut4 (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in(in_bit4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out(out_bit4),
        .out_sop(out_sop4), .out_eop(out_eop4)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output capture: a bit is taken when valid&&ready seen at the falling edge.
    logic cap_d [0:255];
    logic cap_s [0:255];
    logic cap_e [0:255];
    int   cap_c [0:255];
    int   cap_n = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && cap_n < 256) begin
            cap_d[cap_n] = out_bit;
            cap_s[cap_n] = out_sop;
            cap_e[cap_n] = out_eop;
            cap_c[cap_n] = cyc;
            cap_n++;
        end
    end

    logic cap4_d [0:63];
    logic cap4_s [0:63];
    logic cap4_e [0:63];
    int   cap4_n   = 0;
    int   hold_err = 0;
    int   stall_n  = 0;
    logic p_stall  = 1'b0;
    logic [3:0] p_vals = 4'h0;
    always @(negedge clk) begin
        if (p_stall && ({out_valid4, out_bit4, out_sop4, out_eop4} !== p_vals)) hold_err++;
        p_stall = (rst_n === 1'b1) && out_valid4 && !out_ready4;
        if (p_stall) stall_n++;
        p_vals  = {out_valid4, out_bit4, out_sop4, out_eop4};
        if (rst_n === 1'b1 && out_valid4 === 1'b1 && out_ready4 === 1'b1 && cap4_n < 64) begin
            cap4_d[cap4_n] = out_bit4;
            cap4_s[cap4_n] = out_sop4;
            cap4_e[cap4_n] = out_eop4;
            cap4_n++;
        end
    end

    int base;
    int guard;
    logic [63:0] gd, gs, ge;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // bits[i] is d_i; in_valid is held across the word.
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            int g;
            g = 0;
            in_bit   = bits[i];
            in_valid = 1'b1;
            while (!in_ready && g < 100) begin
                tick();
                g++;
            end
            check("in_ready_wait", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int g;
        g = 0;
        while ((cap_n - base) < n && g < 200) begin
            tick();
            g++;
        end
        check("drain_count", 64'(cap_n - base), 64'(n));
    endtask

    task automatic gather();
        gd = '0; gs = '0; ge = '0;
        for (int i = 0; i < (cap_n - base) && i < 64; i++) begin
            gd[i] = cap_d[base + i];
            gs[i] = cap_s[base + i];
            ge[i] = cap_e[base + i];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_bit4 = 1'b0; out_ready4 = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) tick();

        // Reset values
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out",       64'(out_bit),   64'd0);
        check("rst_out_sop",   64'(out_sop),   64'd0);
        check("rst_out_eop",   64'(out_eop),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_in_ready4", 64'(in_ready4), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single word 1,0,1,1 with latency checks
        base = cap_n;
        send_bits(32'b1101, 4);
        check("w1_full_in_ready",  64'(in_ready),  64'd0);
        check("w1_full_out_valid", 64'(out_valid), 64'd0);
        tick();
        check("w1_load_out_valid", 64'(out_valid), 64'd1);
        check("w1_load_sop",       64'(out_sop),   64'd1);
        check("w1_load_out",       64'(out_bit),   64'd0);
        check("w1_load_in_ready",  64'(in_ready),  64'd1);
        drain(N3);
        gather();
        check("w1_data", gd, A_VEC);
        check("w1_sop",  gs, 64'd1);
        check("w1_eop",  ge, 64'd1 << (N3 - 1));
        check("w1_idle_out_valid", 64'(out_valid), 64'd0);

        // Back-to-back 0000 then 1111
        base = cap_n;
        send_bits(32'b0000, 4);
        send_bits(32'b1111, 4);
        drain(2 * N3);
        gather();
        check("b2b_data", gd, ((64'd1 << N3) - 64'd1) << N3);
        check("b2b_sop",  gs, 64'd1 | (64'd1 << N3));
        check("b2b_eop",  ge, (64'd1 << (N3 - 1)) | (64'd1 << (2 * N3 - 1)));
        check("b2b_no_gap", 64'(cap_c[base + 2 * N3 - 1] - cap_c[base]), 64'(2 * N3 - 1));

        // M=4, 11 ones, out_ready toggling
        in_valid4 = 1'b1; in_bit4 = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        in_valid4 = 1'b0;
        check("m4_full_in_ready",  64'(in_ready4),  64'd0);
        check("m4_full_out_valid", 64'(out_valid4), 64'd0);
        tick();
        check("m4_load_out_valid", 64'(out_valid4), 64'd1);
        check("m4_load_sop",       64'(out_sop4),   64'd1);
        check("m4_load_in_ready",  64'(in_ready4),  64'd1);
        guard = 0;
        while (cap4_n < N4 && guard < 200) begin
            out_ready4 = !out_ready4;
            tick();
            guard++;
        end
        out_ready4 = 1'b0;
        gd = '0; gs = '0; ge = '0;
        for (int i = 0; i < cap4_n && i < 64; i++) begin
            gd[i] = cap4_d[i];
            gs[i] = cap4_s[i];
            ge[i] = cap4_e[i];
        end
        check("m4_count", 64'(cap4_n), 64'(N4));
        check("m4_data",  gd, (64'd1 << N4) - 64'd1);
        check("m4_sop",   gs, 64'd1);
        check("m4_eop",   ge, 64'd1 << (N4 - 1));
        check("m4_hold_err", 64'(hold_err), 64'd0);
        check("m4_stalled", 64'(stall_n > 0), 64'd1);

        // Backpressure: stall after 2 output bits while word 2 arrives
        base = cap_n;
        send_bits(32'b1101, 4);
        repeat (3) tick();
        out_ready = 1'b0;
        check("bp_two_bits", 64'(cap_n - base), 64'd2);
        send_bits(32'b0110, 4);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        repeat (5) tick();
        check("bp_in_ready_held", 64'(in_ready), 64'd0);
        check("bp_still_two",     64'(cap_n - base), 64'd2);
        check("bp_out_valid",     64'(out_valid), 64'd1);
        out_ready = 1'b1;
        drain(2 * N3);
        gather();
        check("bp_data", gd, A_VEC | (B_VEC << N3));
        check("bp_sop",  gs, 64'd1 | (64'd1 << N3));
        check("bp_eop",  ge, (64'd1 << (N3 - 1)) | (64'd1 << (2 * N3 - 1)));

        // Reset mid-output with a partial word in the collector
        send_bits(32'b1101, 4);
        repeat (3) tick();
        send_bits(32'b11, 2);
        check("rst2_mid_output", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_out",       64'(out_bit),   64'd0);
        check("rst2_out_sop",   64'(out_sop),   64'd0);
        check("rst2_out_eop",   64'(out_eop),   64'd0);
        check("rst2_in_ready",  64'(in_ready),  64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        base = cap_n;
        send_bits(32'b1101, 4);
        tick();
        check("rst2_first_sop", 64'(out_sop), 64'd1);
        drain(N3);
        gather();
        check("rst2_data", gd, A_VEC);
        check("rst2_sop",  gs, 64'd1);
        check("rst2_eop",  ge, 64'd1 << (N3 - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_hamming_encoder.md
# serial_hamming_encoder

Parametrised serial Hamming block encoder. Collects K data bits from a 1-bit serial stream under a valid/ready handshake and computes a (2^M−1, K) Hamming codeword, optionally extended with an overall parity bit. The codeword is emitted serially under a valid/ready handshake with start- and end-of-word markers. It sits between the bit source and the OFDM symbol mapper, and is the generalised successor of the fixed 4-bit-in / 8-bit-out encoder.

## Interface
- M, 3, parity bit count (3..5); K = 2^M−1−M data bits per word (4, 11, 26)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input bit valid
- in_ready  out  1  input can accept a bit; combinational = !full
- in  in  1  serial data bit
- out_valid  out  1  output bit valid
- out_ready  in  1  downstream accepts output bit
- out  out  1  serial codeword bit
- out_sop  out  1  high with the first bit of a codeword
- out_eop  out  1  high with the last bit of a codeword

## Operation
- Two stages: input collector (K-bit shift register, count 0..K, full flag) and output shifter (N-bit register, bit index, busy flag).
- Input accept: in_valid && in_ready. The i-th accepted bit (i = 0..K−1) is data bit d_i. On acceptance of d_{K−1}, full is set and count returns to 0.
- Codeword positions 1..2^M−1. Parity bits sit at power-of-two positions. d_0..d_{K−1} fill the remaining positions in ascending order.
- Parity bit p_{2^j} = XOR of all data positions whose index has bit j set.
- Load: when full && (!busy || last bit accepted this cycle), the shifter loads the codeword at that edge, busy is set and full is cleared.
- Output order: ascending position (optional position 0 first, see Configuration). A bit advances on out_valid && out_ready. out/out_sop/out_eop hold while stalled.
- The last bit is accepted without a pending load: busy clears, out_valid falls.
- Collector accepts the next word while the shifter is busy. Input stalls (in_ready=0) only while full.
- No mid-word abort. Gaps in in_valid simply pause collection.

## Timing
- Reset values: out_valid 0, out 0, out_sop 0, out_eop 0, in_ready 1; count 0, full 0, busy 0.
- Reset asserted mid-word discards the partial collector word and the in-flight codeword immediately; first output after release starts a fresh word.
- Latency: d_{K−1} accepted at edge t → full at t; load at t+1; out_valid=1 with out_sop=1 from t+1.
- in_ready low for exactly one cycle per word when the shifter is idle. It stays low longer while the shifter drains.
- Back-to-back: eop accepted at edge e while full → new word loaded at e, out_valid stays 1, out_sop=1 in the next cycle, no bubble.
- Simultaneous full-set and shifter finishing: load occurs on the following edge, one-cycle out_valid gap.
- Throughput bound by output: N cycles per word at out_ready=1.

## Configuration
- HAMMING_OVERALL_PARITY_EN defined: N = 2^M. Position 0 carries even parity over positions 1..2^M−1 and is emitted first (with out_sop).
- Not defined: N = 2^M−1. Emission starts at position 1 (with out_sop). No overall parity logic.

## Test plan
- M=3, macro on, in = 1,0,1,1 with in_valid held, out_ready=1 → out = 0,0,1,1,0,0,1,1; sop on bit 0, eop on bit 7; first out_valid one cycle after collector full.
- M=3, macro off, same input → out = 0,1,1,0,0,1,1; eop on the 7th bit.
- M=3, macro on, 0000 then 1111 back-to-back → 00000000 then 11111111 with no out_valid gap between words.
- M=4, macro on, 11 ones → 16 ones. out_ready toggled 1/0 each cycle → each bit held while stalled; in_ready low until the word loads.
- out_ready=0 after 2 output bits while a second word is sent → in_ready falls after the 4th bit of word 2 and stays low; release out_ready → words emitted in order, intact.
- reset pulsed low after 2 input bits and mid-output → outputs at reset values immediately; following word 1,0,1,1 encodes correctly.
